// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI3-style INCR-burst slave backed by a word-addressed RAM.
// Independent write (AW/W/B) and read (AR/R) FSMs, one outstanding burst each,
// bursts of 1-16 full-width beats.
// Optional macro AXI_MEM_RESP_RANGE_CHECK_EN: beats that fall beyond the RAM
// depth are dropped (write) or zero-filled (read) and answered with SLVERR
// instead of wrapping the word index.
module axi_mem_responder #(
    parameter int AXI_TID_WIDTH = 6,
    parameter int ADDR_W        = 32,
    parameter int AXI_DATA_W    = 64,
    parameter int AXI_WSTRB_W   = AXI_DATA_W / 8,
    parameter int MEM_ADDR_W    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    // write address
    input  logic [AXI_TID_WIDTH-1:0] S_AXI_AWID,
    input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
    input  logic [3:0]               S_AXI_AWLEN,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    // write data
    input  logic [AXI_DATA_W-1:0]    S_AXI_WDATA,
    input  logic [AXI_WSTRB_W-1:0]   S_AXI_WSTRB,
    input  logic                     S_AXI_WLAST,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    // write response
    output logic [AXI_TID_WIDTH-1:0] S_AXI_BID,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    // read address
    input  logic [AXI_TID_WIDTH-1:0] S_AXI_ARID,
    input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
    input  logic [3:0]               S_AXI_ARLEN,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    // read data
    output logic [AXI_TID_WIDTH-1:0] S_AXI_RID,
    output logic [AXI_DATA_W-1:0]    S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RLAST,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    // status
    output logic [15:0]              wr_burst_count,
    output logic [15:0]              rd_burst_count,
    output logic                     wlast_err
);

    localparam int BYTE_SH = $clog2(AXI_WSTRB_W);
    localparam int DEPTH   = 1 << MEM_ADDR_W;
`ifdef AXI_MEM_RESP_RANGE_CHECK_EN
    // Full word address plus one spare bit so beat offsets never wrap.
    localparam int WA_W = ADDR_W - BYTE_SH + 1;
`else
    localparam int WA_W = MEM_ADDR_W;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [AXI_DATA_W-1:0] mem [DEPTH];

    logic [WA_W-1:0] aw_word;
    logic [WA_W-1:0] ar_word;
    logic            unused_addr;

`ifdef AXI_MEM_RESP_RANGE_CHECK_EN
    assign aw_word     = {1'b0, S_AXI_AWADDR[ADDR_W-1:BYTE_SH]};
    assign ar_word     = {1'b0, S_AXI_ARADDR[ADDR_W-1:BYTE_SH]};
    assign unused_addr = ^{S_AXI_AWADDR[BYTE_SH-1:0], S_AXI_ARADDR[BYTE_SH-1:0], S_AXI_WLAST};
`else
    assign aw_word     = S_AXI_AWADDR[MEM_ADDR_W+BYTE_SH-1:BYTE_SH];
    assign ar_word     = S_AXI_ARADDR[MEM_ADDR_W+BYTE_SH-1:BYTE_SH];
    assign unused_addr = ^{S_AXI_AWADDR[ADDR_W-1:MEM_ADDR_W+BYTE_SH], S_AXI_AWADDR[BYTE_SH-1:0],
                           S_AXI_ARADDR[ADDR_W-1:MEM_ADDR_W+BYTE_SH], S_AXI_ARADDR[BYTE_SH-1:0],
                           S_AXI_WLAST};
`endif

    // ---------------------------------------------------------------- write
    w_state_t                 w_state_q, w_state_d;
    logic [AXI_TID_WIDTH-1:0] w_id_q, w_id_d;
    logic [WA_W-1:0]          w_addr_q, w_addr_d;
    logic [3:0]               w_len_q, w_len_d;
    logic [3:0]               w_cnt_q, w_cnt_d;
    logic                     w_err_q, w_err_d;
    logic                     awready_q, awready_d;
    logic [15:0]              wr_cnt_q, wr_cnt_d;
    logic                     wlast_err_q, wlast_err_d;
    logic                     aw_hs, w_hs, w_is_last, w_oor, mem_we;
    logic [MEM_ADDR_W-1:0]    w_idx;

    assign aw_hs     = S_AXI_AWVALID && awready_q;
    assign w_hs      = S_AXI_WVALID && (w_state_q == W_DATA);
    assign w_is_last = (w_cnt_q == w_len_q);
    assign w_idx     = w_addr_q[MEM_ADDR_W-1:0];
`ifdef AXI_MEM_RESP_RANGE_CHECK_EN
    assign w_oor     = |w_addr_q[WA_W-1:MEM_ADDR_W];
`else
    assign w_oor     = 1'b0;
`endif

    // Write FSM next-state: latch AW, count W beats, hold B until accepted.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_state_d   = w_state_q;
        w_id_d      = w_id_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_err_d     = w_err_q;
        wr_cnt_d    = wr_cnt_q;
        wlast_err_d = wlast_err_q;
        mem_we      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_id_d    = S_AXI_AWID;
                    w_addr_d  = aw_word;
                    w_len_d   = S_AXI_AWLEN;
                    w_cnt_d   = 4'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    mem_we   = !w_oor;
                    w_err_d  = w_err_q || w_oor;
                    w_addr_d = w_addr_q + WA_W'(1);
                    w_cnt_d  = w_cnt_q + 4'd1;
                    // The beat count ends the burst; WLAST is only cross-checked.
                    if (S_AXI_WLAST != w_is_last) wlast_err_d = 1'b1;
                    if (w_is_last) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wr_cnt_d  = wr_cnt_q + 16'd1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
    end

    // Write FSM state and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            w_state_q   <= W_IDLE;
            w_id_q      <= '0;
            w_addr_q    <= '0;
            w_len_q     <= '0;
            w_cnt_q     <= '0;
            w_err_q     <= 1'b0;
            awready_q   <= 1'b0;
            wr_cnt_q    <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            w_id_q      <= w_id_d;
            w_addr_q    <= w_addr_d;
            w_len_q     <= w_len_d;
            w_cnt_q     <= w_cnt_d;
            w_err_q     <= w_err_d;
            awready_q   <= awready_d;
            wr_cnt_q    <= wr_cnt_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    // Byte-strobed RAM write port.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array has no reset; only control state is cleared.
        if (mem_we) begin
            for (int b = 0; b < AXI_WSTRB_W; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    r_state_t                 r_state_q, r_state_d;
    logic [AXI_TID_WIDTH-1:0] r_id_q, r_id_d;
    logic [WA_W-1:0]          r_addr_q, r_addr_d;
    logic [3:0]               r_len_q, r_len_d;
    logic [3:0]               r_beat_q, r_beat_d;
    logic [AXI_DATA_W-1:0]    rdata_q, rdata_d;
    logic                     rerr_q, rerr_d;
    logic                     arready_q, arready_d;
    logic [15:0]              rd_cnt_q, rd_cnt_d;
    logic                     ar_hs, r_is_last, fetch, fetch_oor;
    logic [WA_W-1:0]          fetch_addr;

    assign ar_hs      = S_AXI_ARVALID && arready_q;
    assign r_is_last  = (r_beat_q == r_len_q);
    // R_FETCH loads the current beat; a handshake in R_DATA prefetches the next one.
    assign fetch_addr = (r_state_q == R_DATA) ? r_addr_q + WA_W'(1) : r_addr_q;
`ifdef AXI_MEM_RESP_RANGE_CHECK_EN
    assign fetch_oor  = |fetch_addr[WA_W-1:MEM_ADDR_W];
`else
    assign fetch_oor  = 1'b0;
`endif

    // Read FSM next-state plus the RDATA fetch (reads before same-cycle writes land).
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        rd_cnt_d  = rd_cnt_q;
        fetch     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_id_d    = S_AXI_ARID;
                    r_addr_d  = ar_word;
                    r_len_d   = S_AXI_ARLEN;
                    r_beat_d  = 4'd0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                fetch     = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    if (r_is_last) begin
                        rd_cnt_d  = rd_cnt_q + 16'd1;
                        r_state_d = R_IDLE;
                    end else begin
                        fetch    = 1'b1;
                        r_addr_d = fetch_addr;
                        r_beat_d = r_beat_q + 4'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (fetch) begin
            rdata_d = fetch_oor ? '0 : mem[fetch_addr[MEM_ADDR_W-1:0]];
            rerr_d  = fetch_oor;
        end
        arready_d = (r_state_d == R_IDLE);
    end

    // Read FSM state, RDATA register and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
            arready_q <= 1'b0;
            rd_cnt_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
            arready_q <= arready_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign S_AXI_AWREADY  = awready_q;
    assign S_AXI_WREADY   = (w_state_q == W_DATA);
    assign S_AXI_BVALID   = (w_state_q == W_RESP);
    assign S_AXI_BID      = w_id_q;
    assign S_AXI_BRESP    = {w_err_q, 1'b0};
    assign S_AXI_ARREADY  = arready_q;
    assign S_AXI_RVALID   = (r_state_q == R_DATA);
    assign S_AXI_RID      = r_id_q;
    assign S_AXI_RDATA    = rdata_q;
    assign S_AXI_RRESP    = {rerr_q, 1'b0};
    assign S_AXI_RLAST    = (r_state_q == R_DATA) && r_is_last;
    assign wr_burst_count = wr_cnt_q;
    assign rd_burst_count = rd_cnt_q;
    assign wlast_err      = wlast_err_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed bench for axi_mem_responder. Stimulus tasks push
// expected B and R responses into queues; a monitor pops and compares on every
// handshake and checks that stalled R beats hold steady.
module tb_axi_mem_responder;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [3:0]  awlen, arlen;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [15:0] wr_burst_count, rd_burst_count;
    logic        wlast_err;

    b_exp_t bq[$];
    r_exp_t rq[$];
    int checks = 0;
    int errors = 0;
    int b_seen = 0;
    int r_seen = 0;
    int b_total = 0;
    int r_total = 0;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk(clk), .reset(reset),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .wr_burst_count(wr_burst_count), .rd_burst_count(rd_burst_count),
        .wlast_err(wlast_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_b(input logic [5:0] id, input logic [1:0] resp);
        bq.push_back('{id: id, resp: resp});
        b_total++;
    endtask

    task automatic push_r(input logic [5:0] id, input logic [63:0] data,
                          input logic [1:0] resp, input logic last);
        rq.push_back('{id: id, data: data, resp: resp, last: last});
        r_total++;
    endtask

    task automatic do_ar(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len);
        int n = 0;
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 50) begin n++; @(negedge clk); end
        check("ar_accepted", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [63:0] base, input logic [7:0] strb,
                            input int last_beat, input logic [1:0] exp_resp);
        int n = 0;
        push_b(id, exp_resp);
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 50) begin n++; @(negedge clk); end
        check("aw_accepted", 64'(awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = base + 64'(b);
            wstrb = strb;
            wlast = (b == last_beat);
            n = 0;
            @(negedge clk);
            while (!wready && n < 50) begin n++; @(negedge clk); end
            check("w_accepted", 64'(wready), 64'd1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic wait_b(input int target);
        int n = 0;
        while (b_seen < target && n < 100) begin @(posedge clk); n++; end
        check("b_received", 64'(b_seen), 64'(target));
    endtask

    task automatic wait_r(input int target);
        int n = 0;
        while (r_seen < target && n < 200) begin @(posedge clk); n++; end
        check("r_received", 64'(r_seen), 64'(target));
    endtask

    // Monitor: scoreboard compare on every B/R handshake, plus R stall stability.
    initial begin : monitor
        b_exp_t      be;
        r_exp_t      re;
        logic        stall = 1'b0;
        logic [63:0] stall_data = '0;
        logic        stall_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        check("b_unexpected", 64'd1, 64'd0);
                    end else begin
                        be = bq.pop_front();
                        check("bid", 64'(bid), 64'(be.id));
                        check("bresp", 64'(bresp), 64'(be.resp));
                    end
                    b_seen++;
                end
                if (stall) begin
                    check("r_stall_valid", 64'(rvalid), 64'd1);
                    check("r_stall_data", rdata, stall_data);
                    check("r_stall_last", 64'(rlast), 64'(stall_last));
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        check("r_unexpected", 64'd1, 64'd0);
                    end else begin
                        re = rq.pop_front();
                        check("rid", 64'(rid), 64'(re.id));
                        check("rdata", rdata, re.data);
                        check("rresp", 64'(rresp), 64'(re.resp));
                        check("rlast", 64'(rlast), 64'(re.last));
                    end
                    r_seen++;
                end
                stall      = rvalid && !rready;
                stall_data = rdata;
                stall_last = rlast;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [15:0] rd_before;
        int          b_before;
        int          n;
        reset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_counts", 64'({wr_burst_count, rd_burst_count}), 64'd0);
        check("rst_wlast_err", 64'(wlast_err), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("arready_before_edge", 64'(arready), 64'd0);
        @(negedge clk);
        check("arready_after_edge", 64'(arready), 64'd1);
        check("awready_after_edge", 64'(awready), 64'd1);

        // Single-beat write/read with AR-to-RVALID latency.
        do_write(6'd5, 32'h40, 4'd0, 64'h1122334455667788, 8'hFF, 0, 2'b00);
        wait_b(b_total);
        push_r(6'd9, 64'h1122334455667788, 2'b00, 1'b1);
        do_ar(6'd9, 32'h40, 4'd0);
        @(negedge clk);
        check("rvalid_fetch_cycle", 64'(rvalid), 64'd0);
        @(negedge clk);
        check("rvalid_two_cycles", 64'(rvalid), 64'd1);
        wait_r(r_total);

        // 16-beat write then full-rate 16-beat read.
        do_write(6'd1, 32'h100, 4'd15, 64'd0, 8'hFF, 15, 2'b00);
        wait_b(b_total);
        rd_before = rd_burst_count;
        for (int i = 0; i < 16; i++) push_r(6'd2, 64'(i), 2'b00, i == 15);
        do_ar(6'd2, 32'h100, 4'd15);
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rvalid) n++;
        end
        check("rvalid_run_16", 64'(n), 64'd16);
        wait_r(r_total);
        @(negedge clk);
        check("rvalid_after_burst", 64'(rvalid), 64'd0);
        check("rd_count_delta", 64'(rd_burst_count - rd_before), 64'd1);
        check("wlast_err_clean", 64'(wlast_err), 64'd0);

        // Partial strobe: only the low four bytes are cleared.
        do_write(6'd3, 32'h200, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 2'b00);
        do_write(6'd3, 32'h200, 4'd0, 64'h0, 8'h0F, 0, 2'b00);
        wait_b(b_total);
        push_r(6'd3, 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1);
        do_ar(6'd3, 32'h200, 4'd0);
        wait_r(r_total);

        // Read backpressure: RREADY pattern 1,0,0,1,0,0,...
        for (int i = 0; i < 4; i++) push_r(6'd6, 64'(i), 2'b00, i == 3);
        do_ar(6'd6, 32'h100, 4'd3);
        n = 0;
        while (r_seen < r_total && n < 60) begin
            rready = (n % 3 == 0);
            @(posedge clk); #1;
            n++;
        end
        rready = 1'b1;
        check("bp_beats_done", 64'(r_seen), 64'(r_total));

        // Early WLAST: flagged, sticky, burst still runs to four beats.
        b_before = b_seen;
        do_write(6'd7, 32'h300, 4'd3, 64'hA0, 8'hFF, 1, 2'b00);
        wait_b(b_total);
        repeat (5) @(posedge clk);
        check("wlast_single_b", 64'(b_seen), 64'(b_before + 1));
        check("wlast_err_set", 64'(wlast_err), 64'd1);
        for (int i = 0; i < 4; i++) push_r(6'd7, 64'hA0 + 64'(i), 2'b00, i == 3);
        do_ar(6'd7, 32'h300, 4'd3);
        wait_r(r_total);
        do_write(6'd8, 32'h400, 4'd0, 64'h55, 8'hFF, 0, 2'b00);
        wait_b(b_total);
        check("wlast_err_sticky", 64'(wlast_err), 64'd1);

        // Top-of-RAM burst: word 1023 then 1024 (out of range or wrapping to 0).
`ifdef AXI_MEM_RESP_RANGE_CHECK_EN
        do_write(6'd10, 32'h1FF8, 4'd1, 64'hDEAD_0000, 8'hFF, 1, 2'b10);
        wait_b(b_total);
        push_r(6'd11, 64'hDEAD_0000, 2'b00, 1'b0);
        push_r(6'd11, 64'h0, 2'b10, 1'b1);
`else
        do_write(6'd10, 32'h1FF8, 4'd1, 64'hDEAD_0000, 8'hFF, 1, 2'b00);
        wait_b(b_total);
        push_r(6'd11, 64'hDEAD_0000, 2'b00, 1'b0);
        push_r(6'd11, 64'hDEAD_0001, 2'b00, 1'b1);
`endif
        do_ar(6'd11, 32'h1FF8, 4'd1);
        wait_r(r_total);

        // Reset during beat 2 of an 8-beat read.
        for (int i = 0; i < 8; i++) push_r(6'd4, 64'(i), 2'b00, i == 7);
        do_ar(6'd4, 32'h100, 4'd7);
        wait_r(r_seen + 2);
        #1;
        check("rvalid_beat2", 64'(rvalid), 64'd1);
        reset = 1'b1;
        #1;
        check("rvalid_drop_on_reset", 64'(rvalid), 64'd0);
        rq.delete();
        r_total = r_seen;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("arready_held_low", 64'(arready), 64'd0);
        check("counts_cleared", 64'({wr_burst_count, rd_burst_count}), 64'd0);
        check("wlast_err_cleared", 64'(wlast_err), 64'd0);
        @(negedge clk);
        check("arready_back", 64'(arready), 64'd1);
        push_r(6'd12, 64'h1122334455667788, 2'b00, 1'b1);
        do_ar(6'd12, 32'h40, 4'd0);
        wait_r(r_total);
        @(negedge clk);
        check("rd_count_after_reset", 64'(rd_burst_count), 64'd1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- Synthesizable AXI3-style slave that answers the memory controller's master port (AW/W/B/AR/R) from an internal word-addressed RAM.
- Used as the DDR stand-in for loopback and DNN bring-up benches and on-chip smoke tests.
- Read and write channels run independent FSMs, one outstanding burst per direction, INCR bursts of 1-16 beats.

Parameters:
- AXI_TID_WIDTH, 6, ID width on AW/W/B/AR/R.
- ADDR_W, 32, byte address width.
- AXI_DATA_W, 64, data width; byte count is AXI_DATA_W/8, a power of two.
- AXI_WSTRB_W, AXI_DATA_W/8, strobe width.
- MEM_ADDR_W, 10, log2 of RAM depth in words.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- S_AXI_AWID/AWADDR/AWLEN  in  AXI_TID_WIDTH/ADDR_W/4  write address, ID and length-1
- S_AXI_AWVALID  in  1 ; S_AXI_AWREADY  out  1
- S_AXI_WDATA/WSTRB/WLAST/WVALID  in  AXI_DATA_W/AXI_WSTRB_W/1/1  write data; S_AXI_WREADY  out  1
- S_AXI_BID  out  AXI_TID_WIDTH ; S_AXI_BRESP  out  2 ; S_AXI_BVALID  out  1 ; S_AXI_BREADY  in  1
- S_AXI_ARID/ARADDR/ARLEN  in  AXI_TID_WIDTH/ADDR_W/4 ; S_AXI_ARVALID  in  1 ; S_AXI_ARREADY  out  1
- S_AXI_RID  out  AXI_TID_WIDTH ; S_AXI_RDATA  out  AXI_DATA_W ; S_AXI_RRESP  out  2 ; S_AXI_RLAST/RVALID  out  1 ; S_AXI_RREADY  in  1
- wr_burst_count  out  16  completed write bursts (B handshakes), wraps at 2^16
- rd_burst_count  out  16  completed read bursts (RLAST handshakes), wraps at 2^16
- wlast_err  out  1  sticky: WLAST disagreed with the beat count
- AWSIZE/AWBURST/ARSIZE/ARBURST/LOCK/CACHE/PROT/QOS/WID are not ports; the master drives full-width INCR.

Behaviour:
- Reset: all outputs 0, FSMs idle, counters 0, wlast_err 0. RAM contents are not reset.
- AWREADY and ARREADY are registered and rise on the first clk edge after reset deasserts.
- Reset mid-burst drops the burst. Beats already written stay in RAM.
- Word index: addr[MEM_ADDR_W+log2(bytes)-1 : log2(bytes)]. Low address bits are ignored. Index increments by 1 per beat and wraps modulo 2^MEM_ADDR_W.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On AW handshake, latch id/index/len, clear beat count, go to W_DATA with AWREADY=0.
  - W_DATA: WREADY=1. Each W handshake writes the RAM bytes whose WSTRB bit is 1; other bytes are unchanged.
  - On the beat where count==len, go to W_RESP. WLAST != (count==len) sets wlast_err; WLAST never ends the burst.
  - W_RESP: BVALID=1, BID=latched id, BRESP=00. On BREADY go to W_IDLE, increment wr_burst_count, AWREADY=1 next cycle.
  - AW-to-first-WREADY latency: 1 cycle. Back-to-back W beats: 1 per cycle.
- Read FSM, R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: ARREADY=1. On AR handshake, latch id/index/len and go to R_FETCH.
  - R_FETCH: register RAM[index] into the RDATA register, then go to R_DATA.
  - R_DATA: RVALID=1, RID=latched id, RRESP=00, RLAST=(beat==len).
  - On an RREADY handshake that is not last, prefetch RAM[index+1] in the same cycle, so sustained throughput is 1 beat per cycle. RVALID holds and RDATA is stable while RREADY=0.
  - Last handshake: go to R_IDLE and increment rd_burst_count.
  - AR handshake to first RVALID: 2 cycles.
- Simultaneous read fetch and write to the same word in the same cycle: the read returns the pre-write value.
- Read and write bursts proceed concurrently with no mutual stall.

Optional Feature:
- Macro: AXI_MEM_RESP_RANGE_CHECK_EN.
- Defined:
  - Any beat whose full word address (addr >> log2(bytes), plus beat offset) is >= 2^MEM_ADDR_W is out of range and does not wrap.
  - Write beats out of range are discarded. If any beat of a burst was out of range, BRESP=10 (SLVERR).
  - Read beats out of range return RDATA=0 and RRESP=10. In-range beats of the same burst return 00.
- Undefined: no range check, index wraps, and responses are always 00.

Test Plan:
- Single write, AWADDR=0x40, AWLEN=0, WDATA=0x1122334455667788, WSTRB=0xFF, then read 0x40 len 0 -> BRESP=00, BID=AWID; RDATA=0x1122334455667788, RLAST=1, RVALID 2 cycles after the AR handshake.
- 16-beat write at 0x100 with data = beat index, then 16-beat read with RREADY held high -> 16 consecutive RVALID cycles carrying data 0..15, RLAST on beat 15, rd_burst_count=1.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF then 0 with WSTRB=0x0F to the same word -> read 0xFFFF_FFFF_0000_0000.
- Read backpressure: 4-beat read with RREADY toggled 1,0,0,1,... -> RDATA/RLAST stable while stalled, data in order, no beat lost.
- WLAST asserted on beat 1 of an AWLEN=3 burst -> wlast_err=1 and sticky, burst completes after 4 beats, single B response.
- Reset pulse during beat 2 of an 8-beat read -> RVALID=0 immediately, ARREADY returns 1 the first edge after release, and a new read succeeds. With AXI_MEM_RESP_RANGE_CHECK_EN defined, a read at word 1023 len 1 with MEM_ADDR_W=10 -> beat 0 RRESP=00, beat 1 RRESP=10 with RDATA=0.
